mem_writeback_stage: RTL and testbench

//   Stage directly downstream of the 8-bit ALU. It registers the ALU result and flags.
//   It writes results back to the register file and holds the architectural flag register.
//   It runs the multi-cycle LOAD/STORE handshake with data memory.

---
 rtl/mem_writeback_stage.sv | 116 +++++++++++
 tb/tb_mem_writeback_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback_stage.sv
// rtl/mem_writeback_stage.sv - ALU result writeback, flag register and load/store memory handshake
module mem_writeback_stage #(
    parameter int DW      = 8,
    parameter int RAW     = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_is_data,
    input  logic [1:0]     in_data_op,
    input  logic           in_wb_en,
    input  logic [RAW-1:0] in_rd,
    input  logic [DW-1:0]  in_result,
    input  logic [DW-1:0]  in_addr,
    input  logic [DW-1:0]  in_sdata,
    input  logic [4:0]     in_flags,
    output logic           rf_we,
    output logic [RAW-1:0] rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic [4:0]     flags_q,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    input  logic [DW-1:0]  mem_rdata,
    output logic           mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t         state;
    logic [7:0]     tmo_cnt;
    logic [RAW-1:0] lat_rd;
    logic [DW-1:0]  ld_data;
    logic           accept;
    logic           is_mem_op;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    // data_op[1] selects LOAD/STORE, data_op[0] distinguishes STORE from LOAD
    assign is_mem_op = in_is_data & in_data_op[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            lat_rd    <= '0;
            ld_data   <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            flags_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem_op) begin
                            lat_rd    <= in_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= in_data_op[0];
                            mem_addr  <= in_addr;
                            mem_wdata <= in_sdata;
                            tmo_cnt   <= '0;
                            state     <= REQ;
                        end else begin
                            rf_we    <= in_wb_en;
                            rf_waddr <= in_rd;
                            rf_wdata <= in_result;
                            if (!in_is_data)
                                flags_q <= in_flags;
                        end
                    end
                end
                REQ: begin
                    // an ack in the final allowed cycle takes priority over the timeout
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                        if (mem_we) begin
                            state <= IDLE;
                        end else begin
                            ld_data <= mem_rdata;
                            state   <= WB;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WB: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= lat_rd;
                    rf_wdata <= ld_data;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb/tb_mem_writeback_stage.sv - randomized self-checking bench for mem_writeback_stage
module tb_mem_writeback_stage;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_ready, in_is_data, in_wb_en;
    logic [1:0] in_data_op;
    logic [2:0] in_rd;
    logic [7:0] in_result, in_addr, in_sdata;
    logic [4:0] in_flags;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [4:0] flags_q;
    logic       mem_req, mem_we, mem_ack, mem_err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [4:0] m_flags = '0;
    logic       m_err = 1'b0;

    mem_writeback_stage #(.DW(8), .RAW(3), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_data(in_is_data),
        .in_data_op(in_data_op), .in_wb_en(in_wb_en), .in_rd(in_rd),
        .in_result(in_result), .in_addr(in_addr), .in_sdata(in_sdata),
        .in_flags(in_flags), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flags_q(flags_q), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        in_is_data = 1'($urandom);
        in_data_op = 2'($urandom);
        in_wb_en   = 1'($urandom);
        in_rd      = 3'($urandom);
        in_result  = 8'($urandom);
        in_addr    = 8'($urandom);
        in_sdata   = 8'($urandom);
        in_flags   = 5'($urandom);
    endtask

    // Arithmetic, MOVE or FLAG op: writeback next cycle, flags only for arithmetic
    task automatic arith(input logic is_data, input logic [1:0] op, input logic wb,
                         input logic [2:0] rd, input logic [7:0] res,
                         input logic [4:0] fl, input logic last);
        in_valid = 1'b1; in_is_data = is_data; in_data_op = op; in_wb_en = wb;
        in_rd = rd; in_result = res; in_flags = fl;
        in_addr = 8'($urandom); in_sdata = 8'($urandom);
        check("arith_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        if (!is_data) m_flags = fl;
        check("arith_we", 32'(rf_we), 32'(wb));
        if (wb) begin
            check("arith_waddr", 32'(rf_waddr), 32'(rd));
            check("arith_wdata", 32'(rf_wdata), 32'(res));
        end
        check("arith_flags", 32'(flags_q), 32'(m_flags));
        if (last) in_valid = 1'b0;
    endtask

    // LOAD/STORE; memory acks in REQ cycle k (k > TIMEOUT means never)
    task automatic memop(input logic store, input logic [7:0] addr, input logic [7:0] sdata,
                         input logic [2:0] rd, input int k, input logic [7:0] rdat);
        int n;
        int exp_n;
        in_valid = 1'b1; in_is_data = 1'b1; in_data_op = {1'b1, store};
        in_addr = addr; in_sdata = sdata; in_rd = rd;
        in_wb_en = 1'($urandom); in_result = 8'($urandom); in_flags = 5'($urandom);
        check("mem_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("req_start", 32'(mem_req), 32'd1);
        check("req_ready_low", 32'(in_ready), 32'd0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            randomize_inputs();
            check("req_we", 32'(mem_we), 32'(store));
            check("req_addr", 32'(mem_addr), 32'(addr));
            if (store) check("req_wdata", 32'(mem_wdata), 32'(sdata));
            check("req_no_wb", 32'(rf_we), 32'd0);
            mem_ack = (n == k);
            mem_rdata = (n == k) ? rdat : 8'($urandom);
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        in_valid = 1'b0;
        exp_n = (k <= TIMEOUT) ? k : TIMEOUT;
        if (k > TIMEOUT) m_err = 1'b1;
        check("req_cycles", 32'(n), 32'(exp_n));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("mem_flags", 32'(flags_q), 32'(m_flags));
        if (!store && k <= TIMEOUT) begin
            check("wb_gap", 32'(rf_we), 32'd0);
            check("wb_gap_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check("ld_we", 32'(rf_we), 32'd1);
            check("ld_waddr", 32'(rf_waddr), 32'(rd));
            check("ld_wdata", 32'(rf_wdata), 32'(rdat));
            check("ld_ready", 32'(in_ready), 32'd1);
        end else begin
            check("no_wb", 32'(rf_we), 32'd0);
            check("end_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        check({tag, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
        check({tag, "_flags"}, 32'(flags_q), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_mem_err"}, 32'(mem_err), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        arith(1'b0, 2'b00, 1'b1, 3'd2, 8'h3C, 5'b00010, 1'b1);
        arith(1'b0, 2'b00, 1'b0, 3'd4, 8'h00, 5'b01001, 1'b1);
        memop(1'b0, 8'h40, 8'h00, 3'd5, 3, 8'hA7);
        memop(1'b1, 8'h10, 8'h55, 3'd1, 1, 8'h00);
        memop(1'b0, 8'h22, 8'h00, 3'd6, 99, 8'h00);
        arith(1'b0, 2'b00, 1'b1, 3'd7, 8'h81, 5'b10100, 1'b1);
        memop(1'b0, 8'h33, 8'h00, 3'd3, TIMEOUT, 8'h5A);
        // back-to-back accepts with MOVE and FLAG mixed in
        arith(1'b0, 2'b00, 1'b1, 3'd1, 8'h11, 5'b00001, 1'b0);
        arith(1'b1, 2'b00, 1'b1, 3'd2, 8'h22, 5'b11111, 1'b0);
        arith(1'b1, 2'b01, 1'b1, 3'd3, 8'h33, 5'b10101, 1'b0);
        arith(1'b0, 2'b11, 1'b1, 3'd4, 8'h44, 5'b01110, 1'b1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 5)
                arith(1'($urandom), {1'b0, 1'($urandom)}, 1'($urandom), 3'($urandom),
                      8'($urandom), 5'($urandom), 1'($urandom));
            else
                memop(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                      $urandom_range(1, 18), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                check("idle_no_wb", 32'(rf_we), 32'd0);
            end
        end

        // reset in the middle of an outstanding load
        in_valid = 1'b1; in_is_data = 1'b1; in_data_op = 2'b10;
        in_addr = 8'h77; in_rd = 3'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        m_flags = '0; m_err = 1'b0;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("late_ack_no_wb", 32'(rf_we), 32'd0);
        @(posedge clk); #1;
        check("late_ack_no_wb2", 32'(rf_we), 32'd0);
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_ready", 32'(in_ready), 32'd1);

        arith(1'b0, 2'b00, 1'b1, 3'd5, 8'hC3, 5'b00110, 1'b1);
        memop(1'b0, 8'h99, 8'h00, 3'd0, 2, 8'h3E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
